// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// controller states, forwarding-select encodings and the load-latency range check.
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = 4;

    function automatic bit load_lat_ok(input int lat);
        return (lat >= LOAD_LAT_MIN) && (lat <= LOAD_LAT_MAX);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// One ID source-operand comparator: flags a match against the EX destination
// and picks the forwarding source, the newest producer (EX/MEM) winning.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic [REG_AW-1:0] src_reg,
    input  logic              src_valid,
    input  logic [REG_AW-1:0] ex_dest_reg,
    input  logic [REG_AW-1:0] mem_dest_reg,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_dest_reg,
    input  logic              wb_reg_write,
    output logic              ex_match,
    output logic [1:0]        fwd_sel
);

    // A hardwired zero register is never a real dependency.
    logic src_live;
    assign src_live = src_valid && !((ZERO_REG != 0) && (src_reg == '0));

    assign ex_match = src_live && (src_reg == ex_dest_reg);

    always_comb begin
        fwd_sel = FWD_RF;
        if (src_live && mem_reg_write && (src_reg == mem_dest_reg)) begin
            fwd_sel = FWD_EXMEM;
        end else if (src_live && wb_reg_write && (src_reg == wb_dest_reg)) begin
            fwd_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls of LOAD_LAT cycles, branch flush,
// data-memory freeze, per-source forwarding selects and saturating event counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NSRC*REG_AW-1:0]   id_src_reg,
    input  logic [NSRC-1:0]          id_src_valid,
    input  logic [REG_AW-1:0]        ex_dest_reg,
    input  logic                     ex_reg_write,
    input  logic                     ex_mem_read,
    input  logic                     ex_branch_taken,
    input  logic [REG_AW-1:0]        mem_dest_reg,
    input  logic                     mem_reg_write,
    input  logic [REG_AW-1:0]        wb_dest_reg,
    input  logic                     wb_reg_write,
    input  logic                     mem_busy,
    output logic                     PCWrite,
    output logic                     IFIDWrite,
    output logic                     ST,
    output logic                     IFIDFlush,
    output logic                     pipe_hold,
    output logic [NSRC*2-1:0]        fwd_sel,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic [CNT_W-1:0]         flush_events
);

    generate
        if (!load_lat_ok(LOAD_LAT)) begin : g_bad_load_lat
            $error("hazard_ctrl_unit: LOAD_LAT out of range 1..4");
        end
    endgenerate

    // The first stall cycle is spent in RUN, so LOAD_STALL covers LOAD_LAT-1 cycles.
    localparam logic [1:0] LS_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    hz_state_e        state_reg, state_next;
    logic [1:0]       ls_cnt_reg, ls_cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
    logic [NSRC-1:0]  ex_match;
    logic             load_use;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            hazard_fwd_sel #(
                .REG_AW   (REG_AW),
                .ZERO_REG (ZERO_REG)
            ) u_fwd_sel (
                .src_reg       (id_src_reg[gi*REG_AW +: REG_AW]),
                .src_valid     (id_src_valid[gi]),
                .ex_dest_reg   (ex_dest_reg),
                .mem_dest_reg  (mem_dest_reg),
                .mem_reg_write (mem_reg_write),
                .wb_dest_reg   (wb_dest_reg),
                .wb_reg_write  (wb_reg_write),
                .ex_match      (ex_match[gi]),
                .fwd_sel       (fwd_sel[gi*2 +: 2])
            );
        end
    endgenerate

    assign load_use = ex_mem_read && ex_reg_write && (|ex_match);

    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        ST          = 1'b0;
        IFIDFlush   = 1'b0;
        pipe_hold   = 1'b0;
        state_next  = state_reg;
        ls_cnt_next = ls_cnt_reg;
        if (mem_busy) begin
            pipe_hold = 1'b1;
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else if (state_reg == LOAD_STALL) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            ST        = 1'b1;
            if (ls_cnt_reg == 2'd0) begin
                state_next = RUN;
            end else begin
                ls_cnt_next = ls_cnt_reg - 2'd1;
            end
        end else if (ex_branch_taken) begin
            IFIDFlush = 1'b1;
            ST        = 1'b1;
        end else if (load_use) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            ST        = 1'b1;
            if (LOAD_LAT > 1) begin
                state_next  = LOAD_STALL;
                ls_cnt_next = LS_INIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            ls_cnt_reg    <= 2'd0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ls_cnt_reg <= ls_cnt_next;
            if (!PCWrite && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (IFIDFlush && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_reg;
    assign flush_events = flush_cnt_reg;

`ifndef SYNTHESIS
    // EX holds a bubble during a load stall, so a taken branch there is impossible.
    always @(posedge clk) begin
        if (rst_n && (state_reg == LOAD_STALL)) begin
            assert (!ex_branch_taken);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Two controllers (LOAD_LAT=1/ZERO_REG=0 and LOAD_LAT=3/ZERO_REG=1) share one stimulus
// stream; each is compared every cycle against a remaining-stall-cycles reference model.
module tb_hazard_ctrl_unit;

    localparam int REG_AW = 4;
    localparam int NSRC   = 2;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NSRC*REG_AW-1:0] id_src_reg;
    logic [NSRC-1:0]        id_src_valid;
    logic [REG_AW-1:0]      ex_dest_reg, mem_dest_reg, wb_dest_reg;
    logic                   ex_reg_write, ex_mem_read, ex_branch_taken;
    logic                   mem_reg_write, wb_reg_write, mem_busy;

    logic             pcw [2];
    logic             ifidw [2];
    logic             st [2];
    logic             fl [2];
    logic             hold [2];
    logic [NSRC*2-1:0] fwd [2];
    logic [CNT_W-1:0] stallc [2];
    logic [CNT_W-1:0] flushc [2];

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    // Reference model state: stall cycles still owed, and event counts.
    int rem [2];
    int m_stall [2];
    int m_flush [2];

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_AW(REG_AW), .NSRC(NSRC), .LOAD_LAT(1), .ZERO_REG(0), .CNT_W(CNT_W)
    ) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .id_src_reg(id_src_reg), .id_src_valid(id_src_valid),
        .ex_dest_reg(ex_dest_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_dest_reg(mem_dest_reg),
        .mem_reg_write(mem_reg_write), .wb_dest_reg(wb_dest_reg), .wb_reg_write(wb_reg_write),
        .mem_busy(mem_busy), .PCWrite(pcw[0]), .IFIDWrite(ifidw[0]), .ST(st[0]),
        .IFIDFlush(fl[0]), .pipe_hold(hold[0]), .fwd_sel(fwd[0]),
        .stall_cycles(stallc[0]), .flush_events(flushc[0])
    );

    hazard_ctrl_unit #(
        .REG_AW(REG_AW), .NSRC(NSRC), .LOAD_LAT(3), .ZERO_REG(1), .CNT_W(CNT_W)
    ) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .id_src_reg(id_src_reg), .id_src_valid(id_src_valid),
        .ex_dest_reg(ex_dest_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_dest_reg(mem_dest_reg),
        .mem_reg_write(mem_reg_write), .wb_dest_reg(wb_dest_reg), .wb_reg_write(wb_reg_write),
        .mem_busy(mem_busy), .PCWrite(pcw[1]), .IFIDWrite(ifidw[1]), .ST(st[1]),
        .IFIDFlush(fl[1]), .pipe_hold(hold[1]), .fwd_sel(fwd[1]),
        .stall_cycles(stallc[1]), .flush_events(flushc[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit zr_of(input int k);
        return (k == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic bit src_live(input int k, input int i);
        logic [REG_AW-1:0] r;
        r = id_src_reg[i*REG_AW +: REG_AW];
        return id_src_valid[i] && !(zr_of(k) && (r == 0));
    endfunction

    function automatic logic [NSRC*2-1:0] exp_fwd(input int k);
        logic [NSRC*2-1:0] f;
        logic [REG_AW-1:0] r;
        f = '0;
        for (int i = 0; i < NSRC; i++) begin
            r = id_src_reg[i*REG_AW +: REG_AW];
            if (src_live(k, i) && mem_reg_write && r == mem_dest_reg) f[i*2 +: 2] = 2'b01;
            else if (src_live(k, i) && wb_reg_write && r == wb_dest_reg) f[i*2 +: 2] = 2'b10;
        end
        return f;
    endfunction

    function automatic bit exp_load_use(input int k);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_live(k, i) && id_src_reg[i*REG_AW +: REG_AW] == ex_dest_reg) hit = 1'b1;
        end
        return ex_mem_read && ex_reg_write && hit;
    endfunction

    // Expected control outputs as {PCWrite, IFIDWrite, ST, IFIDFlush, pipe_hold}.
    function automatic logic [4:0] exp_ctrl(input int k);
        if (mem_busy)            return 5'b00001;
        else if (rem[k] > 0)     return 5'b00100;
        else if (ex_branch_taken) return 5'b11110;
        else if (exp_load_use(k)) return 5'b00100;
        else                     return 5'b11000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_no, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [4:0] e;
        for (int k = 0; k < 2; k++) begin
            e = exp_ctrl(k);
            chk($sformatf("pcwrite_d%0d", k),   32'(pcw[k]),   32'(e[4]));
            chk($sformatf("ifidwrite_d%0d", k), 32'(ifidw[k]), 32'(e[3]));
            chk($sformatf("st_d%0d", k),        32'(st[k]),    32'(e[2]));
            chk($sformatf("ifidflush_d%0d", k), 32'(fl[k]),    32'(e[1]));
            chk($sformatf("pipe_hold_d%0d", k), 32'(hold[k]),  32'(e[0]));
            chk($sformatf("fwd_sel_d%0d", k),   32'(fwd[k]),   32'(exp_fwd(k)));
            chk($sformatf("stall_cycles_d%0d", k), 32'(stallc[k]), 32'(m_stall[k]));
            chk($sformatf("flush_events_d%0d", k), 32'(flushc[k]), 32'(m_flush[k]));
        end
    endtask

    task automatic model_update();
        logic [4:0] e;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                rem[k] = 0;
                m_stall[k] = 0;
                m_flush[k] = 0;
            end else begin
                e = exp_ctrl(k);
                if (!e[4] && m_stall[k] < CNT_MAX) m_stall[k]++;
                if (e[1] && m_flush[k] < CNT_MAX) m_flush[k]++;
                if (mem_busy) begin
                end else if (rem[k] > 0) rem[k]--;
                else if (ex_branch_taken) begin
                end else if (exp_load_use(k)) rem[k] = lat_of(k) - 1;
            end
        end
    endtask

    // One clock cycle with the currently driven inputs.
    task automatic cyc();
        #2;
        if (rst_n) check_all();
        $display("cyc %0d rst_n=%b busy=%b br=%b ld=%b exd=%0d src=%0h v=%b | pcw=%b%b st=%b%b fl=%b%b hold=%b%b fwd=%h/%h stall=%0d/%0d",
                 cyc_no, rst_n, mem_busy, ex_branch_taken, ex_mem_read, ex_dest_reg, id_src_reg,
                 id_src_valid, pcw[0], pcw[1], st[0], st[1], fl[0], fl[1], hold[0], hold[1],
                 fwd[0], fwd[1], stallc[0], stallc[1]);
        @(posedge clk);
        #1;
        model_update();
        cyc_no++;
    endtask

    task automatic set_idle();
        rst_n = 1'b1;
        id_src_reg = '0; id_src_valid = '0;
        ex_dest_reg = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_dest_reg = '0; mem_reg_write = 1'b0; wb_dest_reg = '0; wb_reg_write = 1'b0;
        mem_busy = 1'b0;
    endtask

    task automatic set_load(input logic [3:0] dest, input logic [3:0] src);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest_reg = dest;
        id_src_reg = {4'd0, src}; id_src_valid = 2'b01;
    endtask

    task automatic clear_ex();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_branch_taken = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end
        set_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk("reset_pcwrite_l3", 32'(pcw[1]), 32'd1);
        chk("reset_stall_cnt_l3", 32'(stallc[1]), 32'd0);

        // Load r3 in EX, ID reads r3.
        set_load(4'd3, 4'd3);
        cyc();
        clear_ex();
        cyc(); cyc(); cyc();
        chk("lat1_stall_total", 32'(stallc[0]), 32'd1);
        chk("lat3_stall_total", 32'(stallc[1]), 32'd3);
        chk("lat3_back_to_run", 32'(pcw[1]), 32'd1);

        // Load r0: hazard only where r0 is a real register.
        set_load(4'd0, 4'd0);
        cyc();
        clear_ex();
        cyc(); cyc(); cyc();
        chk("zero_reg_no_stall", 32'(stallc[1]), 32'd3);

        // Branch and load-use together: flush wins.
        set_load(4'd3, 4'd3);
        ex_branch_taken = 1'b1;
        cyc();
        clear_ex();
        cyc();
        chk("branch_flush_cnt_l3", 32'(flushc[1]), 32'd1);

        // mem_busy during the LOAD_LAT=3 stall.
        set_load(4'd3, 4'd3);
        cyc();
        clear_ex();
        mem_busy = 1'b1;
        cyc(); cyc();
        mem_busy = 1'b0;
        cyc(); cyc(); cyc();

        // Forwarding priority on r5.
        set_idle();
        mem_dest_reg = 4'd5; mem_reg_write = 1'b1;
        wb_dest_reg = 4'd5; wb_reg_write = 1'b1;
        id_src_reg = {4'd5, 4'd5}; id_src_valid = 2'b11;
        cyc();
        chk("fwd_exmem_wins", 32'(fwd[1]), 32'h5);
        mem_reg_write = 1'b0;
        cyc();
        chk("fwd_memwb", 32'(fwd[1]), 32'hA);

        // Reset abandons a stall in progress.
        set_idle();
        set_load(4'd3, 4'd3);
        cyc();
        clear_ex();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("reset_mid_stall_run", 32'(pcw[1]), 32'd1);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) >= 3);
            id_src_reg = REG_AW'($urandom_range(0, 7)) | (8'($urandom_range(0, 7)) << REG_AW);
            id_src_valid = 2'($urandom_range(0, 3));
            ex_dest_reg = 4'($urandom_range(0, 7));
            ex_reg_write = ($urandom_range(0, 99) < 60);
            ex_mem_read = ($urandom_range(0, 99) < 40);
            ex_branch_taken = (rem[0] == 0) && (rem[1] == 0) && ($urandom_range(0, 99) < 15);
            mem_dest_reg = 4'($urandom_range(0, 7));
            mem_reg_write = $urandom_range(0, 1) == 1;
            wb_dest_reg = 4'($urandom_range(0, 7));
            wb_reg_write = $urandom_range(0, 1) == 1;
            mem_busy = ($urandom_range(0, 99) < 15);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
